// File: rtl/base_system_cpu_mul_seq.sv
// base_system_cpu_mul_seq: multi-cycle 32x32 multiply sequencer for a 3-cell 16x16 array.
// Define CPU_MUL_HIGH_EN to enable the high-word ops (MULXUU/MULXSS/MULXSU) and the second array pass.
module base_system_cpu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE1 = 3'd1;
  localparam logic [2:0] S_SUM1   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef CPU_MUL_HIGH_EN
  localparam logic [2:0] S_SUM2   = 3'd3;
`endif

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [63:0] w_sum1;
  logic        w_hi_op;

  // Pass-1 sum; the hi x hi term is added later in pass 2.
  assign w_sum1 = {32'h0, cell_p1}
                + {16'h0, cell_p2, 16'h0}
                + {16'h0, cell_p3, 16'h0};

`ifdef CPU_MUL_HIGH_EN
  logic [1:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] w_uhi;
  logic [31:0] w_cor_a;
  logic [31:0] w_cor_b;
  logic [31:0] w_hi;

  assign w_hi_op = (r_op != 2'b00);
  // Low half of acc is untouched by p1<<32, so only the top word is summed.
  assign w_uhi   = r_acc[63:32] + cell_p1;
  assign w_cor_a = r_a[31] ? r_b : 32'h0;
  assign w_cor_b = r_b[31] ? r_a : 32'h0;

  // Signed correction of the unsigned high word.
  always_comb begin
    w_hi = w_uhi;
    case (r_op)
      2'b11:   w_hi = w_uhi - w_cor_a;
      2'b10:   w_hi = w_uhi - w_cor_a - w_cor_b;
      default: w_hi = w_uhi;
    endcase
  end

  // Latch op at acceptance and capture the corrected high word in SUM2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op <= 2'b00;
      r_hi <= 32'h0;
    end else begin
      if (req_valid && req_ready)
        r_op <= req_op;
      if (r_state == S_SUM2)
        r_hi <= w_hi;
    end
  end
`else
  logic w_unused;

  assign w_hi_op  = 1'b0;
  assign w_unused = ^{req_op, r_acc[63:32]};
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_ISSUE1;
      S_ISSUE1: w_next = S_SUM1;
`ifdef CPU_MUL_HIGH_EN
      S_SUM1:   w_next = w_hi_op ? S_SUM2 : S_DONE;
      S_SUM2:   w_next = S_DONE;
`else
      S_SUM1:   w_next = S_DONE;
`endif
      S_DONE:   if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Operand latch at acceptance and pass-1 accumulation in SUM1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= 32'h0;
      r_b   <= 32'h0;
      r_acc <= 64'h0;
    end else begin
      if (req_valid && req_ready) begin
        r_a <= req_src1;
        r_b <= req_src2;
      end
      if (r_state == S_SUM1)
        r_acc <= w_sum1;
    end
  end

  // Array operand/enable drive; idle lines are held at zero.
  always_comb begin
    cell_en   = 1'b0;
    cell_src1 = 32'h0;
    cell_src2 = 32'h0;
    if (r_state == S_ISSUE1) begin
      cell_en   = 1'b1;
      cell_src1 = r_a;
      cell_src2 = r_b;
    end else if (r_state == S_SUM1 && w_hi_op) begin
      cell_en   = 1'b1;
      cell_src1 = {16'h0, r_a[31:16]};
      cell_src2 = {16'h0, r_b[31:16]};
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);

`ifdef CPU_MUL_HIGH_EN
  assign resp_data = !resp_valid ? 32'h0 :
                     w_hi_op     ? r_hi  : r_acc[31:0];
`else
  assign resp_data = resp_valid ? r_acc[31:0] : 32'h0;
`endif

endmodule

// File: tb/tb_base_system_cpu_mul_seq.sv
// tb_base_system_cpu_mul_seq: scoreboard bench with a behavioural 3-cell array.
// Expectations follow CPU_MUL_HIGH_EN the same way the design does.
module tb_base_system_cpu_mul_seq;

`ifdef CPU_MUL_HIGH_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;

  always #5 clk = ~clk;

  base_system_cpu_mul_seq dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
  );

  // Behavioural cell array, cleared by the same reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_p1 <= 32'h0;
      cell_p2 <= 32'h0;
      cell_p3 <= 32'h0;
    end else if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_hi(input vec_t v);
    return HI && (v.op != 2'b00);
  endfunction

  // Monitor: pops on the first DONE cycle, then checks hold stability.
  exp_t cur;
  bit   inresp = 1'b0;
  always @(negedge clk) begin
    if (!reset_n || !resp_valid) begin
      inresp = 1'b0;
    end else if (!inresp) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got %h, want none", resp_data);
        cur.d = resp_data;
        cur.c = cyc;
      end else begin
        cur = q.pop_front();
        chk("resp_data", resp_data, cur.d);
        chk("latency_cycle", 32'(cyc), 32'(cur.c));
      end
      inresp = 1'b1;
    end else begin
      chk("resp_hold", resp_data, cur.d);
    end
  end

  // Wait for the outstanding response to drain, scrambling source inputs.
  task automatic wait_done(input int exp_en);
    int en;
    bit ok;
    en = 0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cell_en) en++;
      req_src1 = $urandom;
      req_src2 = $urandom;
      if (q.size() == 0 && !resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no response, want one");
    end
    chk("cell_en_cycles", 32'(en), 32'(exp_en));
  endtask

  task automatic send(input vec_t v);
    bit ok;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_src1  = v.a;
    req_src2  = v.b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got req_ready=0, want 1");
    end
    e.d = is_hi(v) ? v.hi : v.lo;
    e.c = cyc + (is_hi(v) ? 4 : 3);
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done(is_hi(v) ? 2 : 1);
  endtask

  vec_t vt[14] = '{
    '{32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000, 32'h0000_0000},
    '{32'h0001_0000, 32'h0001_0000, 2'b01, 32'h0000_0000, 32'h0000_0001},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 32'h0000_0000},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0001, 32'hFFFF_FFFE},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h0000_0001, 32'h0000_0000},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0001, 32'hFFFF_FFFF},
    '{32'hFFFF_FFFE, 32'h0000_0003, 2'b10, 32'hFFFF_FFFA, 32'hFFFF_FFFF},
    '{32'hFFFF_FFFE, 32'h0000_0003, 2'b00, 32'hFFFF_FFFA, 32'h0000_0000},
    '{32'hFFFF_FFFE, 32'h0000_0003, 2'b01, 32'hFFFF_FFFA, 32'h0000_0002},
    '{32'hFFFF_FFFE, 32'h0000_0003, 2'b11, 32'hFFFF_FFFA, 32'hFFFF_FFFF},
    '{32'h0001_0001, 32'h0001_0001, 2'b00, 32'h0002_0001, 32'h0000_0000},
    '{32'h0001_0001, 32'h0001_0001, 2'b01, 32'h0002_0001, 32'h0000_0001},
    '{32'h8000_0000, 32'h0000_0002, 2'b01, 32'h0000_0000, 32'h0000_0001},
    '{32'h8000_0000, 32'h0000_0002, 2'b10, 32'h0000_0000, 32'hFFFF_FFFF}
  };

  vec_t vb  = '{32'h0000_1234, 32'h0000_0010, 2'b00, 32'h0001_2340, 32'h0};
  vec_t vb2 = '{32'h0001_0001, 32'h0001_0001, 2'b00, 32'h0002_0001, 32'h0};

  initial begin
    exp_t e;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_src1   = 32'h0;
    req_src2   = 32'h0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_cell_en", 32'(cell_en), 32'd0);
    chk("rst_cell_src1", cell_src1, 32'h0);
    chk("rst_cell_src2", cell_src2, 32'h0);
    reset_n = 1'b1;

    // Reset asserted in the middle of ISSUE1 drops the request.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_src1  = 32'hFFFF_FFFF;
    req_src2  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("issue1_cell_en", 32'(cell_en), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_cell_en", 32'(cell_en), 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'h0);
    chk("mid_rst_cell_p1", cell_p1, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vt[i]) send(vt[i]);

    // Backpressure with a second request held during the busy period.
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = vb.op;
    req_src1  = vb.a;
    req_src2  = vb.b;
    chk("bp_accept_ready", 32'(req_ready), 32'd1);
    e.d = vb.lo;
    e.c = cyc + 3;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_op   = vb2.op;
    req_src1 = vb2.a;
    req_src2 = vb2.b;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    chk("bp_resp_data", resp_data, vb.lo);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_hs", 32'(req_ready), 32'd1);
    chk("bp_resp_dropped", 32'(resp_valid), 32'd0);
    e.d = vb2.lo;
    e.c = cyc + 3;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done(1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/base_system_cpu_mul_seq.md
# base_system_cpu_mul_seq

Multi-cycle multiply sequencer for the CPU's three-cell 16x16 partial-product multiplier array. It accepts 32x32 multiply requests over a valid/ready handshake and drives the array's shared operand and enable lines. It combines the registered partial products into the low or high word of the 64-bit product. High-word requests reuse the same array in a second pass. It sits between the execute-stage control and the multiplier cell array and owns the array's enable.

## Interface
Parameters:
- none; all widths fixed (32-bit operands, 16x16 cells, 32-bit cell results).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset. It is also the source of the cell array's aclr.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  2  00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU; each high op returns the high word of the 64-bit product.
- req_src1  in  32  operand A.
- req_src2  in  32  operand B.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  32  result word.
- cell_src1  out  32  operand to array (p1=[15:0]x[15:0], p2=src1[15:0]xsrc2[31:16], p3=src1[31:16]xsrc2[15:0]).
- cell_src2  out  32  operand to array.
- cell_en  out  1  array register enable (products registered one edge after cell_en=1).
- cell_p1, cell_p2, cell_p3  in  32 each  registered unsigned partial products.

## Operation
- Acceptance: on a clock edge with req_valid & req_ready, the sequencer latches A, B and op into internal registers and moves IDLE->ISSUE1.
- ISSUE1:
  - cell_src1=A, cell_src2=B, cell_en=1.
  - Next state is SUM1.
- SUM1:
  - acc[63:0] <= p1 + (p2<<16) + (p3<<16), zero-extended to 64 bits.
  - If op=00, go to DONE.
  - Otherwise issue pass 2 in this same cycle: cell_src1={16'h0,A[31:16]}, cell_src2={16'h0,B[31:16]}, cell_en=1. Go to SUM2.
- SUM2:
  - Compute the unsigned high word: uhi = (acc + (p1<<32))[63:32].
  - Apply the signed correction, mod 2^32:
    - MULXUU: hi=uhi.
    - MULXSU: hi=uhi-(A[31]?B:0).
    - MULXSS: hi=uhi-(A[31]?B:0)-(B[31]?A:0).
  - Store hi, then go to DONE.
- DONE:
  - resp_valid=1.
  - resp_data = acc[31:0] for MUL, or hi for high ops.
  - Held stable while resp_ready=0.
  - On resp_ready=1, go to IDLE.
- cell_en=0 and cell_src*=0 in every state except those listed above. The array holds its last products when not enabled.
- The sequencer handles one request at a time, with no overlap. req_ready=0 outside IDLE; req_valid during busy states is ignored, not queued.
- Operands are consumed only from the latched registers. Changes on req_src* after acceptance have no effect.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_data=0, cell_en=0, cell_src1=0, cell_src2=0. Internal acc, hi and operand registers are 0.
- Latency is counted from the acceptance edge to the first cycle with resp_valid=1:
  - MUL: 3 cycles (ISSUE1, SUM1, DONE).
  - High ops: 4 cycles (ISSUE1, SUM1, SUM2, DONE).
- Minimum request-to-request spacing is latency+1 cycles: the DONE handshake edge returns to IDLE, and the next accept happens on the following edge.
- resp_valid stays high until the edge with resp_ready=1. It deasserts on the cycle after that edge.
- Asserting reset_n low in any state immediately forces the reset values above. The array is cleared by the same reset. There is no partial response afterwards, and the in-flight request is dropped.
- req_valid high while in DONE is not accepted in that cycle, even when resp_ready=1.

## Configuration
- CPU_MUL_HIGH_EN defined: all four ops are supported as described.
- CPU_MUL_HIGH_EN undefined:
  - SUM2 is removed and req_op is ignored.
  - Every request returns the low word with 3-cycle latency.
  - cell_en is asserted only in ISSUE1.

## Test plan
- Reset then idle: reset_n low mid-ISSUE1 -> next cycle req_ready=1, resp_valid=0, cell_en=0, resp_data=0.
- MUL: A=0x0001_0000, B=0x0001_0000, op=00 -> resp_data=0x0000_0000, resp_valid exactly 3 cycles after accept. MULXUU with the same operands -> 0x0000_0001 after 4 cycles.
- A=B=0xFFFF_FFFF:
  - op=00 -> 0x0000_0001.
  - op=01 -> 0xFFFF_FFFE.
  - op=10 -> 0x0000_0000.
  - op=11 -> 0xFFFF_FFFF.
- Signed mix: A=0xFFFF_FFFE (-2), B=0x0000_0003, op=10 -> 0xFFFF_FFFF; op=00 -> 0xFFFF_FFFA.
- Backpressure: A=0x0000_1234, B=0x0000_0010, op=00 with resp_ready low for 5 cycles -> resp_data=0x0001_2340 stable, req_ready=0 throughout. A second req_valid held during this time is accepted only on the edge after the handshake edge.
- Operand isolation: change req_src1/req_src2 every cycle after acceptance -> result matches the values latched at acceptance. cell_en pulses exactly once for MUL and twice for high ops.
